// File: rtl/periph_bus_timeout_bridge.sv
// periph_bus_timeout_bridge: single-outstanding OBI bridge that answers upstream with an error word when the peripheral stalls
package periph_bus_timeout_bridge_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module periph_bus_timeout_bridge
  import periph_bus_timeout_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hBADC_AB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    slave_req_i,
  output obi_resp_t   slave_resp_o,
  output obi_req_t    master_req_o,
  input  obi_resp_t   master_resp_i,
  input  logic        clear_i,
  output logic        timeout_o,
  output logic        timeout_irq_o,
  output logic [31:0] timeout_addr_o
);
  typedef enum logic [2:0] {IDLE, REQ, RSP, TERR, DRAIN} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [15:0] cnt;
  logic        granted;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        up_gnt;
  logic        expired;
  logic        to_terr;
  // the response cycle blocks a new grant so the next transaction starts no earlier than T4
  assign up_gnt  = rst_ni && state == IDLE && !rsp_valid && slave_req_i.req;
  assign expired = cnt == LAST;
  assign to_terr = expired && (state == REQ || (state == RSP && !master_resp_i.rvalid));
  assign slave_resp_o.gnt    = up_gnt;
  assign slave_resp_o.rvalid = rsp_valid;
  assign slave_resp_o.rdata  = rsp_data;
  // a request that timed out before its gnt must stay asserted until the peripheral takes it
  assign master_req_o.req   = state == REQ || ((state == TERR || state == DRAIN) && !granted);
  assign master_req_o.we    = we;
  assign master_req_o.be    = be;
  assign master_req_o.addr  = addr;
  assign master_req_o.wdata = wdata;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      granted        <= 1'b0;
      we             <= 1'b0;
      be             <= '0;
      addr           <= '0;
      wdata          <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      timeout_o      <= 1'b0;
      timeout_irq_o  <= 1'b0;
      timeout_addr_o <= '0;
    end else begin
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      timeout_irq_o <= 1'b0;
      if (clear_i) timeout_o <= 1'b0;
      case (state)
        IDLE: if (up_gnt) begin
          state   <= REQ;
          cnt     <= '0;
          granted <= 1'b0;
          we      <= slave_req_i.we;
          be      <= slave_req_i.be;
          addr    <= slave_req_i.addr;
          wdata   <= slave_req_i.wdata;
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (!expired && master_resp_i.gnt) begin
            granted <= 1'b1;
            state   <= RSP;
          end
        end
        RSP: begin
          cnt <= cnt + 16'd1;
          if (master_resp_i.rvalid) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= master_resp_i.rdata;
          end
        end
        TERR: begin
          granted <= granted | master_resp_i.gnt;
          state   <= master_resp_i.rvalid ? IDLE : DRAIN;
        end
        DRAIN: if (!granted) granted <= master_resp_i.gnt;
               else if (master_resp_i.rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (to_terr) begin
        state          <= TERR;
        granted        <= granted | master_resp_i.gnt;
        rsp_valid      <= 1'b1;
        rsp_data       <= ERR_RDATA;
        timeout_irq_o  <= 1'b1;
        timeout_o      <= 1'b1;
        timeout_addr_o <= addr;
      end
    end
  end
endmodule

// File: tb/tb_periph_bus_timeout_bridge.sv
// tb_periph_bus_timeout_bridge: randomized bench checked against a transaction-level timing model of the bridge
module tb_periph_bus_timeout_bridge;
  import periph_bus_timeout_bridge_pkg::*;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;
  logic        clk = 1'b0;
  logic        rst_n;
  obi_req_t    sreq;
  obi_resp_t   sresp;
  obi_req_t    mreq;
  obi_resp_t   mresp;
  logic        clear;
  logic        tflag;
  logic        irq;
  logic [31:0] taddr;
  int          tests = 0;
  int          fails = 0;
  logic        m_flag = 1'b0;
  logic [31:0] m_addr = '0;

  always #5 clk = ~clk;

  periph_bus_timeout_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .slave_req_i(sreq), .slave_resp_o(sresp),
    .master_req_o(mreq), .master_resp_i(mresp), .clear_i(clear),
    .timeout_o(tflag), .timeout_irq_o(irq), .timeout_addr_o(taddr)
  );

  // Peripheral grants g cycles after the request appears and answers r cycles after its gnt.
  // Relative to the upstream grant at k=0: downstream issue k=1, gnt k=1+g, rvalid k=2+g+r.
  // The transaction completes normally when rvalid lands within TIMEOUT_CYCLES cycles of issue.
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] data,
                         input int g, input int r, input int clr_at);
    int          kr, kend;
    logic        normal, exp_rv, exp_irq, exp_mreq;
    logic [31:0] exp_rd;
    kr     = 2 + g + r;
    normal = (1 + g + r) <= TO - 1;
    kend   = normal ? kr + 2 : (kr == TO + 1 ? TO + 2 : kr + 1);
    for (int k = 0; k < kend; k++) begin
      @(negedge clk);
      if (k == 0) begin
        sreq.req = 1'b1; sreq.we = we; sreq.be = be; sreq.addr = addr; sreq.wdata = wdata;
      end else begin
        sreq.req = 1'($urandom_range(0, 1)); sreq.we = 1'($urandom); sreq.be = 4'($urandom);
        sreq.addr = $urandom; sreq.wdata = $urandom;
      end
      mresp.gnt    = (k == 1 + g);
      mresp.rvalid = (k == kr);
      mresp.rdata  = (k == kr) ? data : $urandom;
      clear        = (k == clr_at);
      #1;
      exp_rv   = normal ? (k == kr + 1) : (k == TO + 1);
      exp_rd   = !exp_rv ? 32'h0 : (normal ? data : ERR);
      exp_irq  = !normal && k == TO + 1;
      exp_mreq = k >= 1 && k <= 1 + g;
      tests++;
      if (sresp.gnt !== (k == 0)) begin
        fails++; $display("FAIL up_gnt k=%0d got %b exp %b", k, sresp.gnt, (k == 0));
      end
      tests++;
      if (sresp.rvalid !== exp_rv) begin
        fails++; $display("FAIL up_rvalid k=%0d got %b exp %b", k, sresp.rvalid, exp_rv);
      end
      tests++;
      if (sresp.rdata !== exp_rd) begin
        fails++; $display("FAIL up_rdata k=%0d got %h exp %h", k, sresp.rdata, exp_rd);
      end
      tests++;
      if (irq !== exp_irq) begin
        fails++; $display("FAIL irq k=%0d got %b exp %b", k, irq, exp_irq);
      end
      tests++;
      if (mreq.req !== exp_mreq) begin
        fails++; $display("FAIL dn_req k=%0d got %b exp %b", k, mreq.req, exp_mreq);
      end
      if (exp_mreq) begin
        tests++;
        if ({mreq.we, mreq.be, mreq.addr, mreq.wdata} !== {we, be, addr, wdata}) begin
          fails++;
          $display("FAIL dn_fields k=%0d got %b/%h/%h/%h exp %b/%h/%h/%h", k,
                   mreq.we, mreq.be, mreq.addr, mreq.wdata, we, be, addr, wdata);
        end
      end
      tests++;
      if (tflag !== m_flag) begin
        fails++; $display("FAIL timeout_flag k=%0d got %b exp %b", k, tflag, m_flag);
      end
      tests++;
      if (taddr !== m_addr) begin
        fails++; $display("FAIL timeout_addr k=%0d got %h exp %h", k, taddr, m_addr);
      end
      if (!normal && k == TO) begin
        m_flag = 1'b1; m_addr = addr;
      end else if (clear) m_flag = 1'b0;
    end
    sreq.req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sreq = '0; mresp = '0; clear = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (sresp !== '0) begin fails++; $display("FAIL reset_up_resp got %h exp 0", sresp); end
    tests++;
    if (mreq !== '0) begin fails++; $display("FAIL reset_dn_req got %h exp 0", mreq); end
    tests++;
    if ({tflag, irq, taddr} !== '0) begin
      fails++; $display("FAIL reset_timeout got %b/%b/%h exp 0/0/0", tflag, irq, taddr);
    end
    rst_n = 1'b1;
    m_flag = 1'b0; m_addr = '0;
  endtask

  task automatic test_zero_wait_read;
    run_txn(1'b0, 4'hF, 32'h1000_0004, 32'h0, 32'h1234_5678, 0, 0, -1);
    tests++;
    if (tflag !== 1'b0) begin fails++; $display("FAIL zw_flag got %b exp 0", tflag); end
  endtask

  task automatic test_slow_gnt_write;
    run_txn(1'b1, 4'h3, 32'h1000_0010, 32'hCAFE_F00D, $urandom, 5, 0, -1);
    tests++;
    if (tflag !== 1'b0) begin fails++; $display("FAIL slow_gnt_flag got %b exp 0", tflag); end
  endtask

  task automatic test_timeout_rsp;
    run_txn(1'b0, 4'hF, 32'h2000_0100, 32'h0, 32'h5555_AAAA, 0, 18, -1);
    tests++;
    if ({tflag, taddr} !== {1'b1, 32'h2000_0100}) begin
      fails++; $display("FAIL rsp_timeout_latch got %b/%h exp 1/20000100", tflag, taddr);
    end
    run_txn(1'b0, 4'hF, 32'h2000_0104, 32'h0, 32'h0BAD_F00D, 0, 1, -1);
  endtask

  task automatic test_timeout_req;
    run_txn(1'b1, 4'hC, 32'h2000_0200, 32'h7777_8888, 32'h9999_0000, 19, 1, -1);
    tests++;
    if (taddr !== 32'h2000_0200) begin
      fails++; $display("FAIL req_timeout_addr got %h exp 20000200", taddr);
    end
  endtask

  task automatic test_boundary;
    run_txn(1'b0, 4'hF, 32'h1000_0020, 32'h0, 32'hB0B0_0001, 2, TO - 4, -1);
    run_txn(1'b0, 4'hF, 32'h1000_0024, 32'h0, 32'hB0B0_0002, TO - 2, 0, -1);
  endtask

  task automatic test_clear;
    run_txn(1'b0, 4'hF, 32'h2000_0300, 32'h0, 32'h0, 0, TO, TO);
    tests++;
    if (tflag !== 1'b1) begin fails++; $display("FAIL clear_vs_set got %b exp 1", tflag); end
    run_txn(1'b0, 4'hF, 32'h1000_0030, 32'h0, 32'h1111_2222, 0, 0, 0);
    tests++;
    if (tflag !== 1'b0) begin fails++; $display("FAIL clear_pulse got %b exp 0", tflag); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 0, 0, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 40));
  endtask

  task automatic test_reset_in_rsp;
    @(negedge clk);
    sreq.req = 1'b1; sreq.we = 1'b0; sreq.be = 4'hF; sreq.addr = 32'h3000_0008; sreq.wdata = '0;
    mresp = '0; clear = 1'b0;
    #1;
    tests++;
    if (sresp.gnt !== 1'b1) begin fails++; $display("FAIL rst_txn_gnt got %b exp 1", sresp.gnt); end
    @(negedge clk);
    sreq.req = 1'b0; mresp.gnt = 1'b1;
    #1;
    tests++;
    if (mreq.req !== 1'b1) begin fails++; $display("FAIL rst_txn_dn_req got %b exp 1", mreq.req); end
    @(negedge clk);
    mresp.gnt = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sresp, mreq, tflag, irq, taddr} !== '0) begin
      fails++;
      $display("FAIL rst_in_rsp got %h/%h/%b/%b/%h exp all 0", sresp, mreq, tflag, irq, taddr);
    end
    m_flag = 1'b0; m_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 4'hF, 32'h1000_0040, 32'h0, 32'hFEED_BEEF, 1, 1, -1);
  endtask

  initial begin
    test_reset;
    test_zero_wait_read;
    test_slow_gnt_write;
    test_timeout_rsp;
    test_timeout_req;
    test_boundary;
    test_clear;
    test_back_to_back;
    test_random;
    test_reset_in_rsp;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
